// File: rtl/if_id_stage.sv
// if_id_stage: instruction-fetch stage of the pipelined MIPS core.
// Holds the PC register, the IF/ID pipeline register, a one-cycle boot
// state, a sticky misalignment flag and a saturating stall counter.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      next_pc,
  input  logic             pc_write,
  input  logic             if_id_write,
  input  logic             flush,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc_plus4,
  output logic             id_valid,
  output logic             misaligned,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned XLEN = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   id_instr_q, id_instr_d;
  logic [XLEN-1:0]   id_pc_plus4_q, id_pc_plus4_d;
  logic              id_valid_q, id_valid_d;
  logic              misaligned_q, misaligned_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]   pc_plus4_c;

  // Sequential PC increment; wraps modulo 2^32
  assign pc_plus4_c = pc_q + XLEN'(4);

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      id_instr_q    <= NOP_INSTR;
      id_pc_plus4_q <= '0;
      id_valid_q    <= 1'b0;
      misaligned_q  <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      misaligned_q  <= misaligned_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Next-state logic: boot cycle injects a bubble, run applies hazard controls
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    misaligned_d  = misaligned_q;
    stall_cnt_d   = stall_cnt_q;

    case (state_q)
      ST_BOOT: begin
        // Hazard inputs are ignored until the pipeline has one clean bubble
        state_d       = ST_RUN;
        pc_d          = RESET_PC;
        id_instr_d    = NOP_INSTR;
        id_pc_plus4_d = '0;
        id_valid_d    = 1'b0;
      end
      ST_RUN: begin
        if (pc_write) begin
          // Low address bits are forced to zero; a non-zero request is flagged
          pc_d = {next_pc[XLEN-1:2], 2'b00};
          if (next_pc[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
          end
        end else if (stall_cnt_q != CNT_MAX) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        // Flush wins over capture so a taken branch always squashes decode
        if (flush) begin
          id_instr_d    = NOP_INSTR;
          id_pc_plus4_d = '0;
          id_valid_d    = 1'b0;
        end else if (if_id_write) begin
          id_instr_d    = imem_instr;
          id_pc_plus4_d = pc_plus4_c;
          id_valid_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_plus4_c;
  assign id_instr     = id_instr_q;
  assign id_pc_plus4  = id_pc_plus4_q;
  assign id_valid     = id_valid_q;
  assign misaligned   = misaligned_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed plan scenarios plus
// randomized stimulus compared against a cycle-level behavioural model.
module tb_if_id_stage;

  localparam int unsigned CW = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic          clk;
  logic          rst_n;
  logic [31:0]   next_pc;
  logic          pc_write;
  logic          if_id_write;
  logic          flush;
  logic [31:0]   imem_instr;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc_plus4;
  logic          id_valid;
  logic          misaligned;
  logic [CW-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_booted;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcp4;
  bit          m_valid;
  bit          m_mis;
  int          m_cnt;

  if_id_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .flush       (flush),
    .imem_instr  (imem_instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .id_instr    (id_instr),
    .id_pc_plus4 (id_pc_plus4),
    .id_valid    (id_valid),
    .misaligned  (misaligned),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_booted = 1'b0;
    m_pc     = 32'h0;
    m_instr  = NOP;
    m_pcp4   = 32'h0;
    m_valid  = 1'b0;
    m_mis    = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".pc"},        pc,                 m_pc);
    check({ctx, ".pc_plus4"},  pc_plus4,           m_pc + 32'd4);
    check({ctx, ".id_instr"},  id_instr,           m_instr);
    check({ctx, ".id_pcp4"},   id_pc_plus4,        m_pcp4);
    check({ctx, ".id_valid"},  32'(id_valid),      32'(m_valid));
    check({ctx, ".misalign"},  32'(misaligned),    32'(m_mis));
    check({ctx, ".stalls"},    32'(stall_cycles),  32'(m_cnt));
  endtask

  // Apply one cycle of inputs, advance the model, then check all outputs
  task automatic step(input bit pcw, input bit ifw, input bit fl,
                      input logic [31:0] npc, input logic [31:0] instr,
                      input string ctx);
    logic [31:0] cur_pc;
    pc_write    = pcw;
    if_id_write = ifw;
    flush       = fl;
    next_pc     = npc;
    imem_instr  = instr;
    @(posedge clk);
    cur_pc = m_pc;
    if (!m_booted) begin
      m_booted = 1'b1;
      m_instr  = NOP;
      m_pcp4   = 32'h0;
      m_valid  = 1'b0;
    end else begin
      if (pcw) begin
        m_pc = npc & 32'hFFFF_FFFC;
        if (npc % 4 != 0) m_mis = 1'b1;
      end else if (m_cnt < (1 << CW) - 1) begin
        m_cnt = m_cnt + 1;
      end
      if (fl) begin
        m_instr = NOP;
        m_pcp4  = 32'h0;
        m_valid = 1'b0;
      end else if (ifw) begin
        m_instr = instr;
        m_pcp4  = cur_pc + 32'd4;
        m_valid = 1'b1;
      end
    end
    #1;
    check_all(ctx);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock
  task automatic async_reset(input string ctx);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] npc;
    int r;
    rst_n       = 1'b0;
    next_pc     = 32'h0;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    flush       = 1'b0;
    imem_instr  = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Boot: first edge is a bubble, second captures the first instruction
    step(1, 1, 0, m_pc + 4, 32'h2008_0005, "boot1");
    check("boot1.pc_const", pc, 32'h0);
    step(1, 1, 0, m_pc + 4, 32'h2008_0005, "boot2");
    check("boot2.pc_const", pc, 32'h4);
    check("boot2.instr_const", id_instr, 32'h2008_0005);
    check("boot2.pcp4_const", id_pc_plus4, 32'h4);
    step(1, 1, 0, m_pc + 4, 32'h0111_1111, "to8");

    // Load-use stall at pc=8
    step(0, 0, 0, m_pc + 4, 32'h0222_2222, "stall1");
    step(0, 0, 0, m_pc + 4, 32'h0222_2222, "stall2");
    check("stall.pc_const", pc, 32'h8);
    check("stall.cnt_const", 32'(stall_cycles), 32'd2);
    step(1, 1, 0, m_pc + 4, 32'h0222_2222, "resume");
    check("resume.pc_const", pc, 32'hC);
    step(1, 1, 0, m_pc + 4, 32'h0333_3333, "to16");

    // Branch flush at pc=16
    step(1, 1, 1, 32'h0000_0040, 32'h0444_4444, "flush");
    check("flush.pc_const", pc, 32'h40);
    check("flush.valid_const", 32'(id_valid), 32'd0);
    step(1, 1, 0, m_pc + 4, 32'h0555_5555, "after_flush");
    check("after_flush.pcp4_const", id_pc_plus4, 32'h44);

    // Flush while stalled
    step(0, 0, 1, m_pc + 4, 32'h0666_6666, "flush_stall");
    check("flush_stall.instr_const", id_instr, NOP);

    // Misalignment and PC wrap
    step(1, 1, 0, 32'h0000_0102, 32'h0777_7777, "misalign");
    check("misalign.pc_const", pc, 32'h100);
    check("misalign.flag_const", 32'(misaligned), 32'd1);
    step(1, 1, 0, 32'hFFFF_FFFC, 32'h0888_8888, "wrap");
    check("wrap.pcp4_const", pc_plus4, 32'h0);
    step(1, 1, 0, m_pc + 4, 32'h0999_9999, "wrapped");
    check("wrapped.pc_const", pc, 32'h0);

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      npc = m_pc + 4;
      else if (r < 95) npc = $urandom() & 32'hFFFF_FFFC;
      else             npc = $urandom();
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 7) == 0), npc, $urandom(), "rnd");
    end

    // Counter saturation from a clean reset
    async_reset("pre_sat");
    step(1, 1, 0, 32'h4, 32'h1234_5678, "sat_boot");
    for (int i = 0; i < 20; i++) step(0, 1, 0, 32'h0, $urandom(), "sat");
    check("sat.cnt_const", 32'(stall_cycles), 32'd15);

    // Final asynchronous reset mid-operation
    async_reset("final_rst");
    check("final_rst.pc_const", pc, 32'h0);
    check("final_rst.cnt_const", 32'(stall_cycles), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core: holds the PC register and the IF/ID pipeline register.
- Consumes the 32-bit next-PC produced by the PC-select 2:1 mux (in1 = pc_plus4 from this block, in2 = branch/jump target).
- Drives the instruction-memory address and the decode stage.
- Implements hazard-unit stall/flush control, a one-cycle boot state, a misalignment flag and a stall performance counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush/reset (sll $0,$0,0).
- CNT_W, 16, width of stall_cycles counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- next_pc  in  32  next PC from PC-select mux output.
- pc_write  in  1  1 = PC loads next_pc this cycle (0 = stall PC).
- if_id_write  in  1  1 = IF/ID register captures this cycle (0 = hold).
- flush  in  1  1 = squash IF/ID contents (taken branch/jump).
- imem_instr  in  32  instruction read combinationally from imem at address pc.
- pc  out  32  current PC (imem address).
- pc_plus4  out  32  pc + 4, fed to PC-select mux in1.
- id_instr  out  32  registered instruction to decode.
- id_pc_plus4  out  32  registered pc+4 to decode.
- id_valid  out  1  1 = id_instr is a real fetched instruction.
- misaligned  out  1  sticky: set when next_pc[1:0] != 0 was loaded.
- stall_cycles  out  CNT_W  saturating count of RUN cycles with pc_write=0.

Behaviour:
- Reset is asynchronous and active-low; one clock, clk. While rst_n=0: pc=RESET_PC, id_instr=NOP_INSTR, id_pc_plus4=0, id_valid=0, misaligned=0, stall_cycles=0, state=BOOT.
- State machine: BOOT -> RUN after exactly one clk edge following rst_n release; RUN is terminal until reset.
- BOOT: PC holds RESET_PC; IF/ID loads NOP_INSTR with id_valid=0; pc_write, if_id_write and flush are ignored; counter does not increment.
- RUN, PC register: if pc_write=1, pc <= {next_pc[31:2], 2'b00}; otherwise pc holds.
- Misalignment: if pc_write=1 and next_pc[1:0]!=0 in RUN, misaligned <= 1. It stays 1 until reset.
- pc_plus4 = pc + 4, combinational, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- RUN, IF/ID priority (highest first):
  - flush=1: id_instr <= NOP_INSTR, id_valid <= 0, id_pc_plus4 <= 0, regardless of if_id_write.
  - if_id_write=1: id_instr <= imem_instr, id_pc_plus4 <= pc_plus4, id_valid <= 1.
  - otherwise: hold all IF/ID outputs.
- flush and pc_write are independent: a flush with pc_write=1 squashes IF/ID and loads the branch target in the same edge.
- Latency: the instruction at address A appears on id_instr one edge after pc==A with if_id_write=1.
- stall_cycles increments by 1 on each RUN edge with pc_write=0. It saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-operation returns all registers to reset values immediately, without waiting for clk, and re-enters BOOT.

Test Plan:
- Boot: release rst_n, drive pc_write=1, if_id_write=1, next_pc=pc_plus4, imem_instr=32'h2008_0005.
  -> First edge: pc stays 0, id_valid=0. Second edge: pc=4, id_instr=32'h2008_0005, id_pc_plus4=4, id_valid=1.
- Load-use stall: in RUN at pc=8, hold pc_write=0 and if_id_write=0 for 2 cycles.
  -> pc stays 8, IF/ID outputs unchanged, stall_cycles=2. Resuming gives pc=12.
- Branch flush: at pc=16, drive flush=1, pc_write=1, next_pc=32'h0000_0040.
  -> pc=0x40, id_instr=0, id_valid=0. The next edge captures the instruction at 0x40 with id_pc_plus4=0x44.
- Flush vs stall: drive flush=1, if_id_write=0, pc_write=0.
  -> id_valid=0, id_instr=NOP_INSTR, pc held, stall_cycles increments.
- Misalign and wrap: load next_pc=32'h0000_0102.
  -> pc=0x100, misaligned=1 (stays set). Load next_pc=32'hFFFF_FFFC -> pc_plus4=0.
- Counter saturation and async reset: CNT_W=4, hold pc_write=0 for 20 cycles -> stall_cycles=15.
  -> Pull rst_n low between edges: all outputs reach reset values before the next clk edge.
